fifo_win_rd: RTL and testbench
==============================

Name: fifo_win_rd

Overview:
- Parametrised sliding-window FIFO for the conv line-buffer path, succeeding the fixed 3-wide pop-1 window FIFO.
- Each accepted read returns NUM_RDATA consecutive entries, starting at the head, in one registered word.
- Each read then removes a runtime-selectable number of entries (stride 0..NUM_RDATA), which supports kernel widths and conv strides.
- Unlike its predecessor, it grants a read only when a full window is present, and it provides a soft clear.

Parameters:
- DAT_WIDTH, 8, width of one entry.
- NUM_RDATA, 3, entries per output window; 1 <= NUM_RDATA <= FF_DEPTH.
- FF_ADDR_WIDTH, 4, address width.
- FF_DEPTH, 16, entry count; must equal 2**FF_ADDR_WIDTH.
- STR_WIDTH, 2, width of rd_stride; must be able to encode NUM_RDATA.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clr  in  1  synchronous soft clear; empties the FIFO
- wr_req  in  1  write request
- wr_data  in  DAT_WIDTH  write data
- rd_req  in  1  window read request
- rd_stride  in  STR_WIDTH  entries to pop on an accepted read
- rd_data  out  DAT_WIDTH*NUM_RDATA  window; lane k = bits [k*DAT_WIDTH +: DAT_WIDTH] = head+k
- rd_data_val  out  1  rd_data valid (one-cycle pulse per accepted read)
- win_avail  out  1  data_counter >= NUM_RDATA
- data_counter  out  FF_ADDR_WIDTH+1  occupancy
- full  out  1  data_counter == FF_DEPTH
- empty  out  1  data_counter == 0

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - data_counter = 0.
  - Both pointers = 0.
  - rd_data = 0.
  - rd_data_val = 0.
  - empty = 1, full = 0, win_avail = 0 (or NUM_RDATA == 0, which is illegal).
  - Memory contents are don't-care (not reset).
- Acceptance:
  - wr_acc = wr_req & ~full.
  - rd_acc = rd_req & win_avail.
  - Both are evaluated on the registered count, so a same-cycle write never enables a read.
- Stride:
  - s = min(rd_stride, NUM_RDATA).
  - s = 0 is a peek: the window is returned and nothing is popped.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr += 1. Pointers wrap modulo FF_DEPTH.
- Read:
  - On rd_acc, lane k <= mem[(rd_ptr+k) mod FF_DEPTH] for k = 0..NUM_RDATA-1.
  - rd_ptr += s and rd_data_val <= 1.
  - Latency is 1 cycle from the accepting edge.
  - If no read is accepted: rd_data <= 0 and rd_data_val <= 0.
- Count: data_counter <= data_counter + wr_acc - (rd_acc ? s : 0). The count never exceeds FF_DEPTH and never underflows, because s <= NUM_RDATA <= count.
- Simultaneous write and read:
  - Both take effect.
  - The window reads pre-edge memory. Lanes are always older than wr_ptr, so there is no bypass.
- Full write: when full, wr_req is dropped silently even if a read is accepted the same cycle. No write-through.
- Wrap-around: a window spanning index FF_DEPTH-1 to 0 is read contiguously.
- clr:
  - Priority: rst > clr > wr/rd.
  - Sets pointers and count to 0, rd_data_val <= 0, rd_data <= 0.
  - A coincident wr/rd is discarded.
- Reset mid-operation: any in-flight rd_data_val is killed; next cycle's outputs are the reset values.

Optional Feature:
- Macro: FIFO_WIN_ERR_EN.
- Defined:
  - Adds output err_flags [1:0], sticky.
  - bit0 = write attempted while full; bit1 = rd_req while ~win_avail.
  - Cleared only by rst or clr.
  - Flags update 1 cycle after the offending request.
- Undefined: the port is absent and the illegal requests are dropped silently.

Decomposition:
- Shared package fifo_win_pkg holds:
  - function clog2;
  - localparam-derivation helpers;
  - the lane-slice helper.
- Sub-module fifo_win_mem:
  - register-array storage with one write port and NUM_RDATA combinational read ports;
  - generate-loop address offsets.
- Top keeps the pointers, count, acceptance logic and output registers.

Test Plan (defaults unless noted):
1. Reset, then write 0x10..0x12, then rd_req with stride=1 → next cycle rd_data={0x12,0x11,0x10}, val=1; count 3→2.
2. Count=2 (0x11, 0x12) and rd_req → no val, count stays 2. With FIFO_WIN_ERR_EN, err_flags=2'b10 next cycle.
3. Fill 16 entries 0x00..0x0F, then wr_req with 0xAA → dropped, full=1, count=16. Then stride=3 read → {0x02,0x01,0x00}, count=13.
4. Wrap-around: pointer at 14, entries 0xE0, 0xF0, 0x01 at indices 14, 15, 0 → rd_data={0x01,0xF0,0xE0}.
5. Same-cycle wr_req (0x55) + rd_req stride=2 with count=5 → count=4, window from the old head, 0x55 stored at the old wr_ptr. stride=0 peek twice → identical windows, count unchanged.
6. clr asserted together with wr_req and rd_req at count=7 → next cycle count=0, empty=1, val=0. Then rst asserted during a valid pulse → all outputs at reset values.

Source files
------------

// File: rtl/fifo_win_pkg.sv
// Shared helpers for the sliding-window FIFO: constant log2, count-width derivation
// and the bit offset of a lane inside a packed window word.
package fifo_win_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Occupancy counter must hold the value FF_DEPTH itself, not just FF_DEPTH-1.
   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/fifo_win_mem.sv
// Window FIFO storage: one synchronous write port and NUM_RDATA combinational read ports
// at consecutive addresses; no backpressure, addresses wrap modulo FF_DEPTH.
module fifo_win_mem
   import fifo_win_pkg::*;
#(
   parameter int DAT_WIDTH     = 8,
   parameter int NUM_RDATA     = 3,
   parameter int FF_ADDR_WIDTH = 4,
   parameter int FF_DEPTH      = 16
) (
   input  logic                           clk,
   input  logic                           i_wr_en,
   input  logic [FF_ADDR_WIDTH-1:0]       i_wr_addr,
   input  logic [DAT_WIDTH-1:0]           i_wr_dat,
   input  logic [FF_ADDR_WIDTH-1:0]       i_rd_addr,
   output logic [DAT_WIDTH*NUM_RDATA-1:0] o_rd_dat
);

   logic [DAT_WIDTH-1:0] r_mem [FF_DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
   end

   // Address arithmetic is FF_ADDR_WIDTH bits wide, so a window past the last entry wraps to 0.
   for (genvar k = 0; k < NUM_RDATA; k++) begin : g_lane
      logic [FF_ADDR_WIDTH-1:0] w_addr;
      assign w_addr = i_rd_addr + FF_ADDR_WIDTH'(k);
      assign o_rd_dat[lane_lsb(k, DAT_WIDTH) +: DAT_WIDTH] = r_mem[w_addr];
   end

endmodule

// File: rtl/fifo_win_rd.sv
// Sliding-window FIFO: returns NUM_RDATA entries from the head 1 cycle after an accepted read, then
// pops rd_stride of them; writes when full and reads without a full window are dropped (FIFO_WIN_ERR_EN adds sticky err_flags).
module fifo_win_rd
   import fifo_win_pkg::*;
#(
   parameter int DAT_WIDTH     = 8,
   parameter int NUM_RDATA     = 3,
   parameter int FF_ADDR_WIDTH = 4,
   parameter int FF_DEPTH      = 16,
   parameter int STR_WIDTH     = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           wr_req,
   input  logic [DAT_WIDTH-1:0]           wr_data,
   input  logic                           rd_req,
   input  logic [STR_WIDTH-1:0]           rd_stride,
   output logic [DAT_WIDTH*NUM_RDATA-1:0] rd_data,
   output logic                           rd_data_val,
   output logic                           win_avail,
   output logic [FF_ADDR_WIDTH:0]         data_counter,
   output logic                           full,
`ifdef FIFO_WIN_ERR_EN
   output logic [1:0]                     err_flags,
`endif
   output logic                           empty
);

   localparam int CW = FF_ADDR_WIDTH + 1;
   localparam logic [31:0] NR32 = NUM_RDATA;

   logic [FF_ADDR_WIDTH-1:0]       r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]                  r_cnt;
   logic [DAT_WIDTH*NUM_RDATA-1:0] r_rd_data;
   logic                           r_rd_val;
   logic [DAT_WIDTH*NUM_RDATA-1:0] w_win;
   logic                           w_full, w_win_avail, w_wr_acc, w_rd_acc, w_wr_en;
   logic [CW-1:0]                  w_s;

   assign w_full      = (r_cnt == CW'(FF_DEPTH));
   assign w_win_avail = (r_cnt >= CW'(NUM_RDATA));
   assign w_wr_acc    = wr_req & ~w_full;
   assign w_rd_acc    = rd_req & w_win_avail;
   // Soft clear and reset discard a coincident write, including its memory update.
   assign w_wr_en     = w_wr_acc & ~rst & ~clr;

   always_comb begin
      w_s = CW'(rd_stride);
      if (32'(rd_stride) > NR32) w_s = CW'(NUM_RDATA);
   end

   fifo_win_mem #(
      .DAT_WIDTH    (DAT_WIDTH),
      .NUM_RDATA    (NUM_RDATA),
      .FF_ADDR_WIDTH(FF_ADDR_WIDTH),
      .FF_DEPTH     (FF_DEPTH)
   ) u_mem (
      .clk      (clk),
      .i_wr_en  (w_wr_en),
      .i_wr_addr(r_wr_ptr),
      .i_wr_dat (wr_data),
      .i_rd_addr(r_rd_ptr),
      .o_rd_dat (w_win)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_rd_data <= '0;
         r_rd_val  <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + FF_ADDR_WIDTH'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + w_s[FF_ADDR_WIDTH-1:0];
         r_cnt     <= r_cnt + CW'(w_wr_acc) - (w_rd_acc ? w_s : '0);
         r_rd_data <= w_rd_acc ? w_win : '0;
         r_rd_val  <= w_rd_acc;
      end
   end

`ifdef FIFO_WIN_ERR_EN
   logic [1:0] r_err;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_err <= 2'b00;
      end else begin
         if (wr_req & w_full)       r_err[0] <= 1'b1;
         if (rd_req & ~w_win_avail) r_err[1] <= 1'b1;
      end
   end

   assign err_flags = r_err;
`endif

   assign rd_data      = r_rd_data;
   assign rd_data_val  = r_rd_val;
   assign win_avail    = w_win_avail;
   assign data_counter = r_cnt;
   assign full         = w_full;
   assign empty        = (r_cnt == '0);

endmodule

// File: tb/tb_fifo_win_rd.sv
// Bench for fifo_win_rd: queue-based reference model checked every cycle, plus directed
// literal expectations for each test-plan scenario.
module tb_fifo_win_rd;
   localparam int DW = 8, NR = 3, AW = 4, DEPTH = 16, SW = 2;

   logic clk = 1'b0, rst = 1'b1, clr = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [SW-1:0] rd_stride = '0;
   logic [DW*NR-1:0] rd_data;
   logic rd_data_val, win_avail, full, empty;
   logic [AW:0] data_counter;
`ifdef FIFO_WIN_ERR_EN
   logic [1:0] err_flags;
`endif

   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   fifo_win_rd #(
      .DAT_WIDTH(DW), .NUM_RDATA(NR), .FF_ADDR_WIDTH(AW), .FF_DEPTH(DEPTH), .STR_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_req(wr_req), .wr_data(wr_data),
      .rd_req(rd_req), .rd_stride(rd_stride), .rd_data(rd_data), .rd_data_val(rd_data_val),
      .win_avail(win_avail), .data_counter(data_counter), .full(full),
`ifdef FIFO_WIN_ERR_EN
      .err_flags(err_flags),
`endif
      .empty(empty)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the FIFO is a queue; a read snapshots the first NR entries, then pops.
   logic [DW-1:0]    q[$];
   logic [DW*NR-1:0] m_data = '0;
   logic             m_val = 1'b0;
   logic [1:0]       m_err = 2'b00;

   always @(posedge clk) begin
      int  s;
      bit  wa, ra;
      if (rst || clr) begin
         q.delete();
         m_data = '0;
         m_val  = 1'b0;
         m_err  = 2'b00;
      end else begin
         wa = wr_req && (q.size() < DEPTH);
         ra = rd_req && (q.size() >= NR);
         s  = (int'(rd_stride) > NR) ? NR : int'(rd_stride);
         if (wr_req && q.size() == DEPTH) m_err[0] = 1'b1;
         if (rd_req && q.size() < NR)     m_err[1] = 1'b1;
         m_val  = ra;
         m_data = '0;
         if (ra) begin
            for (int k = 0; k < NR; k++) m_data[k*DW +: DW] = q[k];
            for (int k = 0; k < s; k++) void'(q.pop_front());
         end
         if (wa) q.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      chk("cmp_count", 64'(data_counter), 64'(q.size()));
      chk("cmp_empty", 64'(empty), 64'(q.size() == 0));
      chk("cmp_full", 64'(full), 64'(q.size() == DEPTH));
      chk("cmp_win_avail", 64'(win_avail), 64'(q.size() >= NR));
      chk("cmp_val", 64'(rd_data_val), 64'(m_val));
      chk("cmp_data", 64'(rd_data), 64'(m_data));
`ifdef FIFO_WIN_ERR_EN
      chk("cmp_err", 64'(err_flags), 64'(m_err));
`endif
   end

   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic [SW-1:0] s, input logic c);
      wr_req = w; wr_data = d; rd_req = r; rd_stride = s; clr = c;
      @(negedge clk);
      wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
   endtask

   task automatic wr(input logic [DW-1:0] d);
      cyc(1'b1, d, 1'b0, '0, 1'b0);
   endtask

   task automatic rd(input logic [SW-1:0] s);
      cyc(1'b0, '0, 1'b1, s, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      chk("reset_count", 64'(data_counter), 64'd0);
      chk("reset_empty", 64'(empty), 64'd1);
      chk("reset_full", 64'(full), 64'd0);
      chk("reset_val", 64'(rd_data_val), 64'd0);
      chk("reset_data", 64'(rd_data), 64'd0);
      rst = 1'b0;

      // 1: basic window read with stride 1
      wr(8'h10); wr(8'h11); wr(8'h12);
      chk("t1_count3", 64'(data_counter), 64'd3);
      rd(2'd1);
      chk("t1_data", 64'(rd_data), 64'h121110);
      chk("t1_val", 64'(rd_data_val), 64'd1);
      chk("t1_count2", 64'(data_counter), 64'd2);

      // 2: read without a full window is refused
      rd(2'd1);
      chk("t2_val", 64'(rd_data_val), 64'd0);
      chk("t2_count", 64'(data_counter), 64'd2);
`ifdef FIFO_WIN_ERR_EN
      chk("t2_err", 64'(err_flags), 64'b10);
`endif

      // 3: fill, overflow write dropped, stride-3 read
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++) wr(DW'(i));
      chk("t3_full", 64'(full), 64'd1);
      wr(8'hAA);
      chk("t3_full_after", 64'(full), 64'd1);
      chk("t3_count16", 64'(data_counter), 64'd16);
`ifdef FIFO_WIN_ERR_EN
      chk("t3_err", 64'(err_flags), 64'b01);
`endif
      rd(2'd3);
      chk("t3_data", 64'(rd_data), 64'h020100);
      chk("t3_count13", 64'(data_counter), 64'd13);

      // 4: window spanning the wrap point
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 14; i++) wr(8'hC0 + DW'(i));
      wr(8'hE0); wr(8'hF0);
      for (int i = 0; i < 4; i++) rd(2'd3);
      rd(2'd2);
      wr(8'h01);
      chk("t4_count", 64'(data_counter), 64'd3);
      rd(2'd3);
      chk("t4_wrap_data", 64'(rd_data), 64'h01F0E0);
      chk("t4_empty", 64'(empty), 64'd1);

      // 5: simultaneous write and read, then peeks
      for (int i = 1; i <= 5; i++) wr(8'h20 + DW'(i));
      cyc(1'b1, 8'h55, 1'b1, 2'd2, 1'b0);
      chk("t5_data", 64'(rd_data), 64'h232221);
      chk("t5_count", 64'(data_counter), 64'd4);
      rd(2'd0);
      chk("t5_peek1", 64'(rd_data), 64'h252423);
      rd(2'd0);
      chk("t5_peek2", 64'(rd_data), 64'h252423);
      chk("t5_peek_count", 64'(data_counter), 64'd4);
      rd(2'd1);
      rd(2'd3);
      chk("t5_new_entry", 64'(rd_data), 64'h552524);

      // 6: clear beats coincident traffic; reset kills a valid pulse
      for (int i = 0; i < 7; i++) wr(8'h70 + DW'(i));
      chk("t6_count7", 64'(data_counter), 64'd7);
      cyc(1'b1, 8'h99, 1'b1, 2'd1, 1'b1);
      chk("t6_clr_count", 64'(data_counter), 64'd0);
      chk("t6_clr_empty", 64'(empty), 64'd1);
      chk("t6_clr_val", 64'(rd_data_val), 64'd0);
      wr(8'h81); wr(8'h82); wr(8'h83);
      rd(2'd1);
      chk("t6_pulse", 64'(rd_data_val), 64'd1);
      chk("t6_pulse_data", 64'(rd_data), 64'h838281);
      rst = 1'b1;
      wr_req = 1'b1; wr_data = 8'hBB;
      @(negedge clk);
      rst = 1'b0; wr_req = 1'b0;
      chk("t6_rst_val", 64'(rd_data_val), 64'd0);
      chk("t6_rst_data", 64'(rd_data), 64'd0);
      chk("t6_rst_count", 64'(data_counter), 64'd0);
      chk("t6_rst_empty", 64'(empty), 64'd1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
